// File: rtl/osc_pkg.sv
// Shared types and constants for the sample-rate oscillator and its neighbours.
package osc_pkg;

    typedef enum logic [1:0] {
        WAVE_SQR = 2'b00,
        WAVE_SAW = 2'b01,
        WAVE_TRI = 2'b10,
        WAVE_OFF = 2'b11
    } wave_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] SAMPLE_MID = 8'h80;

endpackage

// File: rtl/rise_detect.sv
// Registers a synchronous level and flags its rising edge for one cycle.
module rise_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/sample_osc.sv
// Phase-accumulator oscillator: one PCM sample per divider tick, selectable waveform.
module sample_osc
    import osc_pkg::*;
#(
    parameter int unsigned PHASE_W  = 16,
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                en,
    input  logic                newclk,
    input  logic [PHASE_W-1:0]  tone_word,
    input  logic [1:0]          wave_sel,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid
);

    // Midscale scaled to the sample width (8'h80 at the default width).
    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'({SAMPLE_MID, 24'd0} >> (32 - SAMPLE_W));

    function automatic logic [SAMPLE_W-1:0] wave_map(input logic [SAMPLE_W-1:0] p,
                                                     input wave_t               sel);
        logic [SAMPLE_W-1:0] ramp;
        logic [SAMPLE_W-1:0] res;
        ramp = {p[SAMPLE_W-2:0], 1'b0};
        res  = MID;
        case (sel)
            WAVE_SQR: res = p[SAMPLE_W-1] ? '1 : '0;
            WAVE_SAW: res = p;
            WAVE_TRI: res = p[SAMPLE_W-1] ? ~ramp : ramp;
            default:  res = MID;
        endcase
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [PHASE_W-1:0]  phase_sum;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                tick;

    rise_detect u_rise (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (newclk),
        .rise  (tick)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            sample_q <= MID;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    // Entering RUN starts from phase 0, so the first sample is already f(tone_word).
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        phase_sum = ((state_q == RUN) ? phase_q : '0) + tone_word;

        if (tick) begin
            valid_d = 1'b1;
            if (en) begin
                state_d  = RUN;
                phase_d  = phase_sum;
                sample_d = wave_map(phase_sum[PHASE_W-1 -: SAMPLE_W], wave_t'(wave_sel));
            end else begin
                state_d  = IDLE;
                phase_d  = '0;
                sample_d = MID;
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_sample_osc.sv
// Scoreboard bench for sample_osc with a local 200-cycle newclk divider.
module tb_sample_osc;

    logic        clk;
    logic        n_rst;
    logic        en;
    logic        newclk;
    logic [15:0] tone_word;
    logic [1:0]  wave_sel;
    logic [7:0]  sample;
    logic        sample_valid;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          rst_cyc  = 0;
    int          last_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  div_cnt;
    logic        m_prev;
    logic [15:0] m_phase;
    logic [7:0]  exp_q[$];

    sample_osc dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .en           (en),
        .newclk       (newclk),
        .tone_word    (tone_word),
        .wave_sel     (wave_sel),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        else
            n_pass++;
    endtask

    function automatic logic [7:0] ref_wave(input logic [7:0] p, input logic [1:0] sel);
        case (sel)
            2'b00:   return p[7] ? 8'hFF : 8'h00;
            2'b01:   return p;
            2'b10:   return p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            default: return 8'h80;
        endcase
    endfunction

    // Stand-in for clkdiv8k: 200-cycle period, held low in reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!n_rst) begin
            div_cnt <= 8'd0;
            newclk  <= 1'b0;
            rst_cyc <= cyc;
        end else begin
            div_cnt <= (div_cnt == 8'd199) ? 8'd0 : div_cnt + 8'd1;
            newclk  <= (div_cnt >= 8'd100);
        end
    end

    // Reference model: on each newclk rise, push the sample the DUT should emit.
    always @(posedge clk) begin
        logic [15:0] pn;
        if (!n_rst) begin
            m_prev  <= 1'b0;
            m_phase <= 16'h0000;
        end else begin
            m_prev <= newclk;
            if (newclk && !m_prev) begin
                if (en) begin
                    pn = m_phase + tone_word;
                    m_phase <= pn;
                    exp_q.push_back(ref_wave(pn[15:8], wave_sel));
                end else begin
                    m_phase <= 16'h0000;
                    exp_q.push_back(8'h80);
                end
            end
        end
    end

    // Monitor: compare each emitted sample, pulse width and sample spacing.
    always @(negedge clk) begin
        if (sample_valid) begin
            if (exp_q.size() == 0)
                chk("spurious_valid", 32'd1, 32'd0);
            else
                chk("sample", 32'(sample), 32'(exp_q.pop_front()));
            if (prev_valid)
                chk("valid_width", 32'd2, 32'd1);
            if (last_cyc != 0 && last_cyc > rst_cyc)
                chk("valid_gap", 32'(cyc - last_cyc), 32'd200);
            last_cyc <= cyc;
        end
        prev_valid <= sample_valid;
    end

    task automatic get_sample(output logic [7:0] s);
        bit found;
        found = 1'b0;
        s     = 8'h00;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                found = 1'b1;
                s     = sample;
            end
        end
        if (!found)
            chk("timeout", 32'd0, 32'd1);
    endtask

    logic [7:0] s;
    logic [7:0] tri_exp [8] = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F, 8'h00};
    logic [7:0] sqr_exp [3] = '{8'hFF, 8'hFF, 8'h00};

    initial begin
        n_rst     = 1'b0;
        en        = 1'b0;
        tone_word = 16'h0100;
        wave_sel  = 2'b01;

        repeat (4) begin
            @(negedge clk);
            chk("rst_sample", 32'(sample), 32'h80);
            chk("rst_valid", 32'(sample_valid), 32'd0);
        end
        n_rst = 1'b1;

        repeat (2) begin
            get_sample(s);
            chk("idle_sample", 32'(s), 32'h80);
        end

        // Saw ramp including the FF -> 00 wrap.
        en = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            get_sample(s);
            if (i <= 3)   chk("saw_start", 32'(s), 32'(i));
            if (i == 255) chk("saw_top", 32'(s), 32'hFF);
            if (i == 256) chk("saw_wrap", 32'(s), 32'h00);
        end

        // Square from phase 0; a mid-period tone_word change must not show.
        en = 1'b0;
        get_sample(s);
        chk("idle_before_sqr", 32'(s), 32'h80);
        en        = 1'b1;
        wave_sel  = 2'b00;
        tone_word = 16'h4000;
        get_sample(s);
        chk("sqr_0", 32'(s), 32'h00);
        tone_word = 16'h1234;
        repeat (50) @(negedge clk);
        tone_word = 16'h4000;
        for (int i = 0; i < 3; i++) begin
            get_sample(s);
            chk("sqr_seq", 32'(s), 32'(sqr_exp[i]));
        end

        // Triangle from phase 0.
        en = 1'b0;
        get_sample(s);
        chk("idle_before_tri", 32'(s), 32'h80);
        en        = 1'b1;
        wave_sel  = 2'b10;
        tone_word = 16'h2000;
        for (int i = 0; i < 8; i++) begin
            get_sample(s);
            chk("tri_seq", 32'(s), 32'(tri_exp[i]));
        end
        get_sample(s);
        chk("tri_again", 32'(s), 32'h40);

        // One-cycle reset mid-run.
        n_rst = 1'b0;
        @(negedge clk);
        chk("midrst_sample", 32'(sample), 32'h80);
        chk("midrst_valid", 32'(sample_valid), 32'd0);
        n_rst = 1'b1;
        get_sample(s);
        chk("post_rst_tri", 32'(s), 32'h40);
        en = 1'b0;
        get_sample(s);
        chk("disable_tick", 32'(s), 32'h80);

        // Zero tone holds; silence still advances phase.
        en        = 1'b1;
        wave_sel  = 2'b01;
        tone_word = 16'h0000;
        repeat (3) begin
            get_sample(s);
            chk("tone_zero", 32'(s), 32'h00);
        end
        wave_sel  = 2'b11;
        tone_word = 16'h0100;
        repeat (3) begin
            get_sample(s);
            chk("silence", 32'(s), 32'h80);
        end
        wave_sel = 2'b01;
        get_sample(s);
        chk("silence_phase_kept", 32'(s), 32'h04);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
